// File: rtl/stopwatch_display.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_display
// Description : Multiplexed 4-digit 7-segment driver for an MM:SS stopwatch
//               with frame-coherent digit snapshot and adjust-mode blinking.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_display #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       adj,
    input  logic       sel,
    input  logic [2:0] m10,
    input  logic [3:0] m1,
    input  logic [2:0] s10,
    input  logic [3:0] s1,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int c_REFRESH_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_FRAME_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [c_REFRESH_W-1:0] c_REFRESH_MAX = c_REFRESH_W'(REFRESH_DIV - 1);
    localparam logic [c_FRAME_W-1:0]   c_FRAME_MAX   = c_FRAME_W'(BLINK_FRAMES - 1);
    localparam logic [6:0] c_SEG_DASH  = 7'b0111111;
    localparam logic [6:0] c_SEG_BLANK = 7'b1111111;

    logic [c_REFRESH_W-1:0] r_refresh;
    logic [1:0]             r_idx;
    logic [c_FRAME_W-1:0]   r_frame;
    logic                   r_phase;   // 1 = hidden
    logic [2:0]             r_snap_m10;
    logic [3:0]             r_snap_m1;
    logic [2:0]             r_snap_s10;
    logic [3:0]             r_snap_s1;

    logic       w_digit_wrap;
    logic       w_frame_end;
    logic       w_blink_wrap;
    logic [3:0] w_val;
    logic       w_tens;
    logic [6:0] w_code;
    logic       w_blank;
    logic [3:0] w_an;
    logic [6:0] w_seg;
    logic       w_dp;

    assign w_digit_wrap = (r_refresh == c_REFRESH_MAX);
    assign w_frame_end  = w_digit_wrap && (r_idx == 2'd3);
    assign w_blink_wrap = (r_frame == c_FRAME_MAX);

    // Scan timing runs purely off the refresh counter, never off the data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_refresh <= '0;
            r_idx     <= 2'd0;
        end else begin
            if (w_digit_wrap) begin
                r_refresh <= '0;
                r_idx     <= r_idx + 2'd1;
            end else begin
                r_refresh <= r_refresh + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_snap_m10 <= '0;
            r_snap_m1  <= '0;
            r_snap_s10 <= '0;
            r_snap_s1  <= '0;
        end else if (w_frame_end) begin
            r_snap_m10 <= m10;
            r_snap_m1  <= m1;
            r_snap_s10 <= s10;
            r_snap_s1  <= s1;
        end
    end

    // Holding the counter at zero outside adjust guarantees a full visible
    // half-period every time adjust mode is entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame <= '0;
            r_phase <= 1'b0;
        end else if (!adj) begin
            r_frame <= '0;
            r_phase <= 1'b0;
        end else if (w_frame_end) begin
            if (w_blink_wrap) begin
                r_frame <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_frame <= r_frame + 1'b1;
            end
        end
    end

    always_comb begin
        w_val  = r_snap_s1;
        w_tens = 1'b0;
        case (r_idx)
            2'd0: begin w_val = r_snap_s1;           w_tens = 1'b0; end
            2'd1: begin w_val = {1'b0, r_snap_s10};  w_tens = 1'b1; end
            2'd2: begin w_val = r_snap_m1;           w_tens = 1'b0; end
            2'd3: begin w_val = {1'b0, r_snap_m10};  w_tens = 1'b1; end
            default: begin w_val = r_snap_s1;        w_tens = 1'b0; end
        endcase
    end

    always_comb begin
        w_code = c_SEG_DASH;
        case (w_val)
            4'd0: w_code = 7'b1000000;
            4'd1: w_code = 7'b1111001;
            4'd2: w_code = 7'b0100100;
            4'd3: w_code = 7'b0110000;
            4'd4: w_code = 7'b0011001;
            4'd5: w_code = 7'b0010010;
            4'd6: w_code = 7'b0000010;
            4'd7: w_code = 7'b1111000;
            4'd8: w_code = 7'b0000000;
            4'd9: w_code = 7'b0010000;
            default: w_code = c_SEG_DASH;
        endcase
        if (w_tens && (w_val > 4'd5)) begin
            w_code = c_SEG_DASH;
        end
    end

    // adj gates the phase directly so dropping adjust shows immediately.
    assign w_blank = adj && r_phase && (sel ? !r_idx[1] : r_idx[1]);

    always_comb begin
        w_an  = ~(4'b0001 << r_idx);
        w_seg = w_blank ? c_SEG_BLANK : w_code;
        w_dp  = (r_idx != 2'd2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= 4'b1111;
            seg <= c_SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= w_an;
            seg <= w_seg;
            dp  <= w_dp;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_display
// Description : Scoreboard bench for stopwatch_display (REFRESH_DIV=4, BLINK_FRAMES=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_display;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       adj;
    logic       sel;
    logic [2:0] m10;
    logic [3:0] m1;
    logic [2:0] s10;
    logic [3:0] s1;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int   checks   = 0;
    int   failures = 0;
    exp_t q[$];

    stopwatch_display #(
        .REFRESH_DIV (4),
        .BLINK_FRAMES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .adj(adj),
        .sel(sel),
        .m10(m10),
        .m1 (m1),
        .s10(s10),
        .s1 (s1),
        .an (an),
        .seg(seg),
        .dp (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] enc(input logic [3:0] v, input bit tens);
        logic [6:0] r;
        case (v)
            4'd0: r = 7'b1000000;
            4'd1: r = 7'b1111001;
            4'd2: r = 7'b0100100;
            4'd3: r = 7'b0110000;
            4'd4: r = 7'b0011001;
            4'd5: r = 7'b0010010;
            4'd6: r = 7'b0000010;
            4'd7: r = 7'b1111000;
            4'd8: r = 7'b0000000;
            4'd9: r = 7'b0010000;
            default: r = 7'b0111111;
        endcase
        if (tens && v > 4'd5) r = 7'b0111111;
        return r;
    endfunction

    task automatic push_slot(input int idx, input logic [3:0] v, input bit tens, input bit blank);
        exp_t e;
        e.an  = 4'b1111;
        e.an[idx] = 1'b0;
        e.dp  = (idx == 2) ? 1'b0 : 1'b1;
        e.seg = blank ? 7'b1111111 : enc(v, tens);
        q.push_back(e);
    endtask

    // hide: 0 = none, 1 = seconds blanked, 2 = minutes blanked
    task automatic push_frame(input logic [3:0] vm10, input logic [3:0] vm1,
                              input logic [3:0] vs10, input logic [3:0] vs1, input int hide);
        push_slot(0, vs1,  1'b0, hide == 1);
        push_slot(1, vs10, 1'b1, hide == 1);
        push_slot(2, vm1,  1'b0, hide == 2);
        push_slot(3, vm10, 1'b1, hide == 2);
    endtask

    // Each slot is sampled on all four of its negedges, so timing is checked too.
    task automatic compare_slots(input string name, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL %s: scoreboard empty at slot %0d", name, i);
                repeat (4) @(negedge clk);
            end else begin
                e = q.pop_front();
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    checks++;
                    if ({an, seg, dp} !== e) begin
                        failures++;
                        $display("FAIL %s slot %0d cyc %0d: got an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b",
                                 name, i, c, an, seg, dp, e.an, e.seg, e.dp);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; adj = 1'b0; sel = 1'b1;
        m10 = 3'd5; m1 = 4'd9; s10 = 3'd3; s1 = 4'd7;
        repeat (3) @(negedge clk);
        checks++;
        if (an !== 4'b1111) begin failures++; $display("FAIL reset_an: got %b expected 1111", an); end
        checks++;
        if (seg !== 7'b1111111) begin failures++; $display("FAIL reset_seg: got %b expected 1111111", seg); end
        checks++;
        if (dp !== 1'b1) begin failures++; $display("FAIL reset_dp: got %b expected 1", dp); end
        rst = 1'b0;
        push_frame(0, 0, 0, 0, 0);
        push_frame(5, 9, 3, 7, 0);
        compare_slots("first_frames", 8);
    endtask

    task automatic test_snapshot();
        push_frame(5, 9, 3, 7, 0);
        compare_slots("snapshot_hold", 2);
        s1 = 4'd2;
        compare_slots("snapshot_hold", 2);
        push_frame(5, 9, 3, 2, 0);
        compare_slots("snapshot_new", 4);
    endtask

    task automatic test_dash();
        s1 = 4'd12; s10 = 3'd6;
        push_frame(5, 9, 3, 2, 0);
        push_frame(5, 9, 6, 12, 0);
        compare_slots("dash", 8);
    endtask

    task automatic test_blink();
        m10 = 3'd1; m1 = 4'd2; s10 = 3'd4; s1 = 4'd5;
        adj = 1'b1; sel = 1'b1;
        push_frame(5, 9, 6, 12, 0);
        push_frame(1, 2, 4, 5, 0);
        push_frame(1, 2, 4, 5, 1);
        push_frame(1, 2, 4, 5, 1);
        push_frame(1, 2, 4, 5, 0);
        push_frame(1, 2, 4, 5, 0);
        push_slot(0, 4'd5, 1'b0, 1'b1);
        push_slot(1, 4'd4, 1'b1, 1'b1);
        compare_slots("blink_sec", 26);
        sel = 1'b0;
        push_slot(2, 4'd2, 1'b0, 1'b1);
        push_slot(3, 4'd1, 1'b1, 1'b1);
        compare_slots("blink_sel_switch", 2);
    endtask

    task automatic test_adj_drop();
        push_slot(0, 4'd5, 1'b0, 1'b0);
        push_slot(1, 4'd4, 1'b1, 1'b0);
        compare_slots("blink_min_hidden", 2);
        adj = 1'b0;
        push_slot(2, 4'd2, 1'b0, 1'b0);
        push_slot(3, 4'd1, 1'b1, 1'b0);
        compare_slots("adj_drop", 2);
        push_frame(1, 2, 4, 5, 0);
        compare_slots("adj_off", 4);
        adj = 1'b1;
        push_frame(1, 2, 4, 5, 0);
        push_frame(1, 2, 4, 5, 0);
        push_frame(1, 2, 4, 5, 2);
        compare_slots("adj_reraise", 11);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (an !== 4'b1111) begin failures++; $display("FAIL midreset_an: got %b expected 1111", an); end
        checks++;
        if (seg !== 7'b1111111) begin failures++; $display("FAIL midreset_seg: got %b expected 1111111", seg); end
        checks++;
        if (dp !== 1'b1) begin failures++; $display("FAIL midreset_dp: got %b expected 1", dp); end
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        push_frame(0, 0, 0, 0, 0);
        push_frame(1, 2, 4, 5, 0);
        push_frame(1, 2, 4, 5, 2);
        compare_slots("after_midreset", 12);
    endtask

    initial begin
        test_reset();
        test_snapshot();
        test_dash();
        test_blink();
        test_adj_drop();
        test_reset_mid();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
